// File: rtl/difftest_commit_sched_if.sv
// WB retire bus and difftest commit bus between the core, the commit sequencer and the DPI sink.
// The slave modport is the sequencer's view; the master modport is the core/checker side.
interface difftest_commit_sched_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        wb_skip;
  logic        wb_ebreak;

  logic        dt_valid;
  logic        dt_ready;
  logic [31:0] dt_pc;
  logic [31:0] dt_inst;
  logic        dt_wen;
  logic [4:0]  dt_rd;
  logic [31:0] dt_wdata;
  logic        dt_skip;
  logic        dt_ebreak;

  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_wen, wb_rd, wb_wdata, wb_skip, wb_ebreak,
    output wb_ready,
    output dt_valid, dt_pc, dt_inst, dt_wen, dt_rd, dt_wdata, dt_skip, dt_ebreak,
    input  dt_ready
  );

  modport master (
    output wb_valid, wb_pc, wb_inst, wb_wen, wb_rd, wb_wdata, wb_skip, wb_ebreak,
    input  wb_ready,
    input  dt_valid, dt_pc, dt_inst, dt_wen, dt_rd, dt_wdata, dt_skip, dt_ebreak,
    output dt_ready
  );
endinterface

// File: rtl/difftest_commit_sched.sv
// Buffers WB retire records and releases them one per checker handshake; drains and halts on
// ebreak, and halts with an error code when the core stops retiring for TIMEOUT cycles.
module difftest_commit_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                          clock,
  input  logic                          reset_n,
  difftest_commit_sched_if.slave        bus,
  input  logic [31:0]                   gpr_a0,
  output logic                          sim_halt,
  output logic [31:0]                   halt_code,
  output logic                          timeout_err,
  output logic [63:0]                   commit_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        skip;
    logic        ebreak;
  } rec_t;

  state_t        state;
  rec_t          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [WW-1:0] wdog;
  logic          full, empty, push, pop;
  rec_t          wr_rec, head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gated by reset_n so the handshake is dead the instant reset asserts, not one edge later.
  assign bus.wb_ready = reset_n && (state == RUN) && !full;
  assign bus.dt_valid = !empty && (state != HALT);

  assign push = bus.wb_valid && bus.wb_ready;
  assign pop  = bus.dt_valid && bus.dt_ready;

  assign wr_rec = '{pc: bus.wb_pc, inst: bus.wb_inst, wen: bus.wb_wen, rd: bus.wb_rd,
                    wdata: bus.wb_wdata, skip: bus.wb_skip, ebreak: bus.wb_ebreak};

  // Head is read straight from the storage registers: no same-cycle bypass of a push.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.dt_pc     = head.pc;
  assign bus.dt_inst   = head.inst;
  assign bus.dt_wen    = head.wen;
  assign bus.dt_rd     = head.rd;
  assign bus.dt_wdata  = head.wdata;
  assign bus.dt_skip   = head.skip;
  assign bus.dt_ebreak = head.ebreak;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_rec;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wdog        <= '0;
      sim_halt    <= 1'b0;
      halt_code   <= '0;
      timeout_err <= 1'b0;
      commit_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        commit_cnt <= commit_cnt + 64'd1;
      end
      case (state)
        RUN: begin
          // A push always clears the watchdog, so an ebreak push beats a same-cycle expiry.
          if (push) begin
            wdog <= '0;
            if (bus.wb_ebreak) begin
              state     <= DRAIN;
              halt_code <= gpr_a0;
            end
          end else begin
            wdog <= wdog + 1'b1;
            if (wdog == WW'(TIMEOUT - 1)) begin
              state       <= HALT;
              sim_halt    <= 1'b1;
              timeout_err <= 1'b1;
              halt_code   <= 32'hFFFF_FFFF;
            end
          end
        end
        DRAIN: begin
          if (empty) begin
            state    <= HALT;
            sim_halt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
